// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and accepted-key results of keypad_scanner.
// The scanner side uses the master modport; the keypad/consumer side uses slave.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] value;

    modport master (input row, output col, key_code, key_valid, key_down, value);
    modport slave  (output row, input col, key_code, key_valid, key_down, value);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, 2-flop row sync, frame-level debounce and multi-key rejection.
// Define KEYPAD_ENTRY_EN to accumulate accepted decimal digits into value (saturating at 999).
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam int         DIV_W = $clog2(SCAN_DIV);
    localparam logic [7:0] DEB_N = 8'(DEBOUNCE_SCANS);

    // Indexed by col*4 + row.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'hE,
        4'h2, 4'h5, 4'h8, 4'h0,
        4'h3, 4'h6, 4'h9, 4'hF,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      frame_q;
    logic             slot_end, frame_end;
    logic [15:0]      frame_bits;
    logic [4:0]       n_pressed;
    logic [3:0]       hit_idx, hit_code;
    logic             single, single_cand;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] key_code_q;
    logic       key_valid_q, key_down_q, key_down_d, accept;

    assign slot_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (col_idx == 2'd3);
    assign kp.col    = ~(4'b0001 << col_idx);

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
            div_cnt  <= '0;
            col_idx  <= '0;
            frame_q  <= '0;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
            if (slot_end) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                case (col_idx)
                    2'd0:    frame_q[3:0]  <= ~row_sync;
                    2'd1:    frame_q[7:4]  <= ~row_sync;
                    2'd2:    frame_q[11:8] <= ~row_sync;
                    default: ;
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Column 3 is taken straight from the synchronizer so the frame resolves on its sample cycle.
    assign frame_bits = {~row_sync, frame_q};

    // NOTE: every variable is assigned a default first, so no path can infer a latch.
    always_comb begin
        n_pressed = '0;
        hit_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_bits[i]) begin
                n_pressed = n_pressed + 5'd1;
                hit_idx   = 4'(i);
            end
        end
    end

    assign hit_code    = KEY_MAP[hit_idx];
    assign single      = (n_pressed == 5'd1);
    assign single_cand = single && (hit_code == cand_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        accept     = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: if (single) begin
                    cand_d = hit_code;
                    cnt_d  = 8'd1;
                    if (DEB_N == 8'd1) begin
                        state_d = PRESSED;
                        accept  = 1'b1;
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: if (single_cand) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == DEB_N) begin
                        state_d = PRESSED;
                        accept  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
                PRESSED: if (!single_cand) begin
                    cnt_d   = 8'd1;
                    state_d = (DEB_N == 8'd1) ? IDLE : RELEASE;
                end
                RELEASE: begin
                    if (single_cand) begin
                        state_d = PRESSED;
                    end else if (single) begin
                        // A different key must re-debounce from IDLE.
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == DEB_N) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        key_down_d = key_down_q;
        if (accept)                 key_down_d = 1'b1;
        else if (state_d == IDLE)   key_down_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= accept;
            key_down_q  <= key_down_d;
            if (accept) key_code_q <= cand_d;
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

`ifdef KEYPAD_ENTRY_EN
    logic [15:0] value_q;
    logic [19:0] value_ext;

    assign value_ext = 20'(value_q) * 20'd10 + 20'(cand_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (accept) begin
            if (cand_d <= 4'd9)       value_q <= (value_ext > 20'd999) ? 16'd999 : value_ext[15:0];
            else if (cand_d == 4'hE)  value_q <= '0;
        end
    end

    assign kp.value = value_q;
`else
    assign kp.value = '0;
`endif
endmodule
